// File: rtl/sensor_emu_ctl_mc_axi_if.sv
// sensor_emu_ctl_mc_axi_if: AXI4-Lite slave bus bundle for the sensor emulator control block
interface sensor_emu_ctl_mc_axi_if;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sensor_emu_ctl_mc_axi.sv
// sensor_emu_ctl_mc_axi: multi-channel AXI4-Lite control/status registers for the emulator FIFO bank
// Define SENSOR_EMU_CTL_WSTRB_EN to make control-register writes honour WSTRB byte lanes.
module sensor_emu_ctl_mc_axi #(
    parameter int NCH = 4,
    parameter int AW  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    sensor_emu_ctl_mc_axi_if.slave s_axi,
    output logic [NCH-1:0]       o_fifo_reset,
    output logic [63:0]          o_load_data,
    output logic [NCH-1:0]       o_load_valid,
    output logic [2:0]           o_start_chan,
    output logic                 o_start,
    output logic                 o_hard_stop,
    input  logic [31:0]          i_module_rev,
    input  logic [3:0]           i_pattern_width,
    input  logic [NCH-1:0]       i_fifo_ready,
    input  logic [NCH-1:0]       i_fifo_full,
    input  logic [32*NCH-1:0]    i_fifo_count,
    input  logic [3:0]           i_active
);
    localparam logic [31:0] AMASK = 32'((64'd1 << AW) - 1);
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic aw_got, w_got, aw_hs, w_hs, ar_hs;
    logic [31:0] aw_addr, w_data, w_idx, r_idx, wmask, nv, rd_val, rdata_q;
    logic [3:0] w_strb;
    logic [31:0] ctl [6];
    logic [NCH-1:0] overrun, ovr_set, ovr_clr, fr_n, lv_n;
    logic [2:0] ci, sel;
    logic nz, err, wr, st_n, hs_n, rd_err;
    logic [1:0] bresp_q, rresp_q;
`ifndef SENSOR_EMU_CTL_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^w_strb;
`endif
    assign s_axi.bresp = bresp_q;
    assign s_axi.rdata = rdata_q;
    assign s_axi.rresp = rresp_q;
    assign o_start_chan = ctl[4][2:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_comb begin
        s_axi.awready = w_state == W_IDLE && !aw_got;
        s_axi.wready = w_state == W_IDLE && !w_got;
        s_axi.bvalid = w_state == W_RESP;
        aw_hs = s_axi.awvalid && s_axi.awready;
        w_hs = s_axi.wvalid && s_axi.wready;
        w_next = w_state == W_IDLE ? (((aw_got || aw_hs) && (w_got || w_hs)) ? W_EXEC : W_IDLE)
               : w_state == W_EXEC ? W_RESP
               : (s_axi.bready ? W_IDLE : W_RESP);
    end
    always_comb begin
        s_axi.arready = r_state == R_IDLE;
        s_axi.rvalid = r_state == R_DATA;
        ar_hs = s_axi.arvalid && s_axi.arready;
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (s_axi.rready ? R_IDLE : R_DATA);
    end
    // Effects of the captured write, applied only while in EXEC
    always_comb begin
        w_idx = (aw_addr & AMASK) >> 2;
        ci = 3'(w_idx - 32'd16);
        sel = ctl[2][2:0];
`ifdef SENSOR_EMU_CTL_WSTRB_EN
        wmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
        nz = |w_strb;
`else
        wmask = '1;
        nz = 1'b1;
`endif
        nv = ((ctl[ci] & ~wmask) | (w_data & wmask)) & ((w_idx == 32'd18 || w_idx == 32'd20) ? 32'h7 : '1);
        err = 1'b0;
        wr = 1'b0;
        fr_n = '0;
        lv_n = '0;
        st_n = 1'b0;
        hs_n = 1'b0;
        ovr_set = '0;
        ovr_clr = '0;
        case (w_idx)
            32'd4: ovr_clr = w_data[NCH-1:0] & wmask[NCH-1:0];
            32'd16: begin
                wr = nz;
                fr_n = nz ? nv[NCH-1:0] : '0;
            end
            32'd17, 32'd18: wr = 1'b1;
            32'd19: if (nz) begin
                if (int'(sel) >= NCH) err = 1'b1;
                else if (|(i_fifo_full & (NCH'(1) << sel))) begin
                    err = 1'b1;
                    ovr_set = NCH'(1) << sel;
                end else begin
                    wr = 1'b1;
                    lv_n = NCH'(1) << sel;
                end
            end
            32'd20: if (nz) begin
                err = int'(nv[2:0]) >= NCH;
                wr = !err;
                st_n = !err;
            end
            32'd21: begin
                wr = nz;
                hs_n = nz;
            end
            default: err = 1'b1;
        endcase
    end
    always_comb begin
        r_idx = (s_axi.araddr & AMASK) >> 2;
        rd_val = '0;
        rd_err = 1'b0;
        case (r_idx)
            32'd0: rd_val = i_module_rev;
            32'd1: rd_val = {28'b0, i_pattern_width};
            32'd2: rd_val = 32'(i_fifo_ready);
            32'd3: rd_val = {28'b0, i_active};
            32'd4: rd_val = 32'(overrun);
            32'd16: rd_val = ctl[0];
            32'd17: rd_val = ctl[1];
            32'd18: rd_val = ctl[2];
            32'd19: rd_val = ctl[3];
            32'd20: rd_val = ctl[4];
            32'd21: rd_val = ctl[5];
            default: rd_err = 1'b1;
        endcase
        for (int n = 0; n < NCH; n++)
            if (r_idx == 32'(8 + n)) begin
                rd_val = i_fifo_count[32*n +: 32];
                rd_err = 1'b0;
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_got <= 1'b0;
            w_got <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            ctl <= '{default: '0};
            overrun <= '0;
            bresp_q <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            o_fifo_reset <= '0;
            o_load_valid <= '0;
            o_load_data <= '0;
            o_start <= 1'b0;
            o_hard_stop <= 1'b0;
        end else begin
            o_fifo_reset <= '0;
            o_load_valid <= '0;
            o_start <= 1'b0;
            o_hard_stop <= 1'b0;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_addr <= s_axi.awaddr;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            if (w_state == W_EXEC) begin
                aw_got <= 1'b0;
                w_got <= 1'b0;
                bresp_q <= err ? 2'b10 : 2'b00;
                if (wr) ctl[ci] <= nv;
                overrun <= (overrun & ~ovr_clr) | ovr_set;
                o_fifo_reset <= fr_n;
                o_load_valid <= lv_n;
                o_start <= st_n;
                o_hard_stop <= hs_n;
                if (|lv_n) o_load_data <= {ctl[1], nv};
            end
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? 2'b11 : 2'b00;
            end
        end
    end
endmodule
